// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and glyph table for the 7-segment scan driver
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] BCD_BLANK = 4'hA;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_GLYPH [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [1:0] SHOW_NORMAL = 2'b00;
    localparam logic [1:0] SHOW_LAP    = 2'b01;
    localparam logic [1:0] SHOW_OFF    = 2'b10;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-low 7-segment glyph, codes 10..15 blank
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_n_o
);

    // Table lookup for decimal digits; anything above 9 is shown blank
    always_comb begin
        seg_n_o = SEG_OFF;
        if (bcd_i <= 4'd9) begin
            seg_n_o = SEG_GLYPH[bcd_i];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 6-digit multiplexed 7-segment scan driver (optional blink: SEG7_BLINK_EN)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int         SCAN_DIV  = 4,
    parameter logic [5:0] DP_MASK   = 6'b001010
`ifdef SEG7_BLINK_EN
    ,
    parameter int         BLINK_DIV = 256
`endif
) (
    input  logic       mili_clk,
    input  logic       reset,
    input  logic [3:0] bch0,
    input  logic [3:0] bch1,
    input  logic [3:0] bch2,
    input  logic [3:0] bch3,
    input  logic [3:0] bch4,
    input  logic [3:0] bch5,
    input  logic [1:0] show_mode,
`ifdef SEG7_BLINK_EN
    input  logic       blink_en,
`endif
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    snap_q [NUM_DIGITS];
    logic [3:0]    snap_d [NUM_DIGITS];
    logic [3:0]    bch_w  [NUM_DIGITS];
    logic          primed_q;
    logic          step_w;
    logic          load_w;
    logic [3:0]    digit_w;
    logic [6:0]    glyph_w;
    logic          blank_w;
    logic [5:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;

    assign bch_w = '{bch0, bch1, bch2, bch3, bch4, bch5};

    // Prescaler/index advance and frame-boundary snapshot capture
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        step_w  = (presc_q == PW'(SCAN_DIV - 1));
        if (step_w) begin
            presc_d = '0;
            idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        load_w = !primed_q || (step_w && idx_q == 3'd5);
        snap_d = load_w ? bch_w : snap_q;
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    // Blink half-period counter; phase flips each time it wraps
    always_comb begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    // Blink counter state register
    always_ff @(posedge mili_clk or negedge reset) begin
        if (!reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blank_w = blink_en && phase_d;
`else
    assign blank_w = 1'b0;
`endif

    assign digit_w = snap_d[idx_d];

    bcd_to_seg7 u_decode (
        .bcd_i   (digit_w),
        .seg_n_o (glyph_w)
    );

    // Output values from next-state index/snapshot so the pins have no lag
    always_comb begin
        an_n_d  = ~(6'd1 << idx_d);
        seg_n_d = glyph_w;
        dp_n_d  = ~(DP_MASK[idx_d] | (show_mode == SHOW_LAP && idx_d == 3'd5));
        if (blank_w) begin
            seg_n_d = SEG_OFF;
            dp_n_d  = 1'b1;
        end
        if (show_mode[1]) begin
            an_n_d  = 6'h3F;
            seg_n_d = SEG_OFF;
            dp_n_d  = 1'b1;
        end
    end

    // Scan state, snapshot and registered outputs
    always_ff @(posedge mili_clk or negedge reset) begin
        if (!reset) begin
            presc_q  <= '0;
            idx_q    <= 3'd0;
            snap_q   <= '{default: BCD_BLANK};
            primed_q <= 1'b0;
            an_n_q   <= 6'h3F;
            seg_n_q  <= SEG_OFF;
            dp_n_q   <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            primed_q <= 1'b1;
            an_n_q   <= an_n_d;
            seg_n_q  <= seg_n_d;
            dp_n_q   <= dp_n_d;
        end
    end

    assign an_n  = an_n_q;
    assign seg_n = seg_n_q;
    assign dp_n  = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized model-checked bench for seg7_scan_driver (SEG7_BLINK_EN aware)
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam logic [5:0] DPM = 6'b001010;
`ifdef SEG7_BLINK_EN
    localparam int BD = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] bch [6];
    logic [1:0] mode = 2'b00;
    logic       blink = 1'b0;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV (SD),
        .DP_MASK  (DPM)
`ifdef SEG7_BLINK_EN
        ,
        .BLINK_DIV(BD)
`endif
    ) dut (
        .mili_clk (clk),
        .reset    (rst),
        .bch0     (bch[0]),
        .bch1     (bch[1]),
        .bch2     (bch[2]),
        .bch3     (bch[3]),
        .bch4     (bch[4]),
        .bch5     (bch[5]),
        .show_mode(mode),
`ifdef SEG7_BLINK_EN
        .blink_en (blink),
`endif
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n)
    );

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t = rising edges since reset release; everything follows from t
    int         t = 0;
    logic [3:0] msnap [6];
    logic [1:0] m_mode = 2'b00;
    logic       m_blink = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t = 0;
        end else begin
            t = t + 1;
            if (t == 1 || (t % (6 * SD)) == 0) msnap = bch;
            m_mode  = mode;
            m_blink = blink;
        end
    end

    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         e_ix;

    always @(negedge clk) begin
        if (!rst || t == 0) begin
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_ix  = (t / SD) % 6;
            e_an  = ~(6'd1 << e_ix);
            e_seg = glyph(msnap[e_ix]);
            e_dp  = !(DPM[e_ix] || (m_mode == 2'b01 && e_ix == 5));
`ifdef SEG7_BLINK_EN
            if (m_blink && ((t / BD) % 2 == 1)) begin
                e_seg = 7'h7F; e_dp = 1'b1;
            end
`endif
            if (m_mode[1]) begin
                e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
            end
        end
        check("scan", {an_n, seg_n, dp_n}, {e_an, e_seg, e_dp});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_an(input logic [5:0] v);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (an_n == v) found = 1;
            else tick();
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_an: got %b expected %b (timeout)", an_n, v);
        end
    endtask

    initial begin
        bch = '{4'hA, 4'hA, 4'h1, 4'h5, 4'h0, 4'h8};
        tick(); tick();
        check("reset_state", {an_n, seg_n, dp_n}, {6'h3F, 7'h7F, 1'b1});

        // Directed frame scan
        rst = 1'b1;
        tick();
        check("first_digit", {an_n, seg_n, dp_n}, {6'b111110, 7'h7F, 1'b1});
        wait_an(6'b111101);
        check("digit1", {7'd0, seg_n, dp_n}, {7'd0, 7'h7F, 1'b0});
        wait_an(6'b111011);
        check("digit2", {7'd0, seg_n, dp_n}, {7'd0, 7'h79, 1'b1});
        wait_an(6'b110111);
        check("digit3", {7'd0, seg_n, dp_n}, {7'd0, 7'h12, 1'b0});
        wait_an(6'b101111);
        check("digit4", {7'd0, seg_n, dp_n}, {7'd0, 7'h40, 1'b1});

        // No tearing: change mid-frame, visible only next frame
        bch[3] = 4'h7;
        bch[5] = 4'h3;
        wait_an(6'b011111);
        check("no_tear", {7'd0, seg_n, dp_n}, {7'd0, 7'h00, 1'b1});
        wait_an(6'b110111);
        check("new_frame_d3", {7'd0, seg_n}, {7'd0, 7'h78});
        wait_an(6'b011111);
        check("new_frame_d5", {7'd0, seg_n}, {7'd0, 7'h30});

        // Display off keeps counting
        mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("off_an", {8'd0, an_n}, {8'd0, 6'h3F});
        end
        mode = 2'b00;

        // Lap-hold lights digit 5 DP
        mode = 2'b01;
        wait_an(6'b011111);
        check("lap_dp5", {13'd0, dp_n}, {13'd0, 1'b0});
        wait_an(6'b111101);
        check("lap_dp1", {13'd0, dp_n}, {13'd0, 1'b0});
        mode = 2'b00;

        // Asynchronous reset mid-frame, then fresh start at digit 0
        wait_an(6'b110111);
        rst = 1'b0;
        #1;
        check("async_reset", {an_n, seg_n, dp_n}, {6'h3F, 7'h7F, 1'b1});
        bch[0] = 4'h8;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("restart_d0", {an_n, seg_n, dp_n}, {6'b111110, 7'h00, 1'b1});

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(0, 19) == 0) bch[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) blink = ~blink;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
